// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP word and the instruction field layout used by IF/ID.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 6;
  localparam int REG_W   = 3;
  localparam int SHAMT_W = 4;

  localparam int OPC_LSB   = 10;
  localparam int SRC_LSB   = 7;
  localparam int DST_LSB   = 4;
  localparam int SHAMT_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_W-1:0] get_src(input logic [INSTR_W-1:0] word);
    return word[SRC_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_dst(input logic [INSTR_W-1:0] word);
    return word[DST_LSB +: REG_W];
  endfunction

  function automatic logic [SHAMT_W-1:0] get_shamt(input logic [INSTR_W-1:0] word);
    return word[SHAMT_LSB +: SHAMT_W];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: the load in ID/EX writes a register that the
// instruction sitting in IF/ID reads or writes.
module load_use_detect
  import fetch_pkg::*;
(
  input  logic             i_id_memread,
  input  logic             i_ifid_valid,
  input  logic [REG_W-1:0] i_id_dst,
  input  logic [REG_W-1:0] i_ifid_src,
  input  logic [REG_W-1:0] i_ifid_dst,
  output logic             o_hazard
);

  assign o_hazard = i_id_memread && i_ifid_valid &&
                    ((i_id_dst == i_ifid_src) || (i_id_dst == i_ifid_dst));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and the IF/ID register, and handles
// load-use stalls, taken-branch flushes and the HALT/resume handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC   = 16'h0000,
  parameter logic [OPC_W-1:0] HLT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               id_memread,
  input  logic [REG_W-1:0]   id_dst,
  input  logic               ex_branch_taken,
  input  logic [PC_W-1:0]    ex_target,
  input  logic               resume,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   src,
  output logic [REG_W-1:0]   dst,
  output logic [SHAMT_W-1:0] shiftamount,
  output logic               ifid_valid,
  output logic               bubble,
  output logic               halted,
  output logic [15:0]        stall_count
);

  fetch_state_e       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic               r_ifid_valid;
  logic [15:0]        r_stall_count;

  logic            w_hazard;
  logic            w_branch;
  logic            w_halt_req;
  logic            w_stall_cycle;
  logic [PC_W-1:0] w_pc_inc;

  load_use_detect u_load_use_detect (
    .i_id_memread (id_memread),
    .i_ifid_valid (r_ifid_valid),
    .i_id_dst     (id_dst),
    .i_ifid_src   (get_src(r_ifid_instr)),
    .i_ifid_dst   (get_dst(r_ifid_instr)),
    .o_hazard     (w_hazard)
  );

  // A HLT waiting in IF/ID wins over a load-use hazard so it is never overwritten by a
  // post-stall refetch; the HLT itself flows into ID/EX, so that cycle is not a bubble.
  assign w_branch      = ex_branch_taken && (r_state != ST_HALT);
  assign w_halt_req    = (r_state == ST_RUN) && r_ifid_valid &&
                         (get_opcode(r_ifid_instr) == HLT_OPCODE);
  assign w_stall_cycle = (r_state == ST_RUN) && !w_branch && !w_halt_req && w_hazard;
  assign w_pc_inc      = r_pc + 16'd1;

  always_comb begin
    bubble = 1'b0;
    if (!rst) begin
      bubble = 1'b0;
    end else if (r_state == ST_HALT) begin
      bubble = 1'b1;
    end else if (w_branch) begin
      bubble = 1'b1;
    end else begin
      bubble = w_stall_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_ifid_instr  <= NOP_WORD;
      r_ifid_valid  <= 1'b0;
      r_stall_count <= 16'h0000;
    end else begin
      if (w_stall_cycle && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (r_state == ST_HALT) begin
        if (resume) begin
          r_ifid_instr <= instr;
          r_ifid_valid <= 1'b1;
          r_pc         <= w_pc_inc;
          r_state      <= ST_RUN;
        end else begin
          r_ifid_valid <= 1'b0;
        end
      end else if (w_branch) begin
        r_pc         <= ex_target;
        r_ifid_instr <= NOP_WORD;
        r_ifid_valid <= 1'b0;
        r_state      <= ST_RUN;
      end else if (w_halt_req) begin
        r_ifid_valid <= 1'b0;
        r_state      <= ST_HALT;
      end else if (w_stall_cycle) begin
        r_state <= ST_STALL;
      end else begin
        r_ifid_instr <= instr;
        r_ifid_valid <= 1'b1;
        r_pc         <= w_pc_inc;
        r_state      <= ST_RUN;
      end
    end
  end

  assign pc          = r_pc;
  assign ifid_instr  = r_ifid_instr;
  assign opcode      = get_opcode(r_ifid_instr);
  assign src         = get_src(r_ifid_instr);
  assign dst         = get_dst(r_ifid_instr);
  assign shiftamount = get_shamt(r_ifid_instr);
  assign ifid_valid  = r_ifid_valid;
  assign halted      = (r_state == ST_HALT);
  assign stall_count = r_stall_count;

endmodule
